// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder (optionally adder/subtractor), LSB first.
// One full-adder cell is reused for W clocks with a registered carry, wrapped
// in a start/ready/done handshake.
//
// Build option: define SERIAL_SUB_EN to add the `sub` port. With sub=1 the
// subtrahend and carry-in are inverted at load time and cout reports borrow.
// Without the macro the block is add-only and no inversion logic exists.
//
// Latency: start accepted at edge k, RUN on edges k+1..k+W, DONE entered at
// edge k+W (sum/cout/done valid the following cycle), IDLE again after k+W+1.

module serial_addsub #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef SERIAL_SUB_EN
    input  logic         sub,
`endif
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q;
    logic [W-1:0]    sa_q;
    logic [W-1:0]    sb_q;
    logic [W-1:0]    acc_q;
    logic            c_q;
    logic [CntW-1:0] cnt_q;
    logic            ready_q;
    logic            busy_q;
    logic            done_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;
`ifdef SERIAL_SUB_EN
    logic            sub_q;
`endif

    // Load-time operand conditioning and final carry/borrow interpretation.
    logic [W-1:0] b_load;
    logic         c_load;
    logic         cout_d;

    // Full-adder cell outputs for the current bit position.
    logic         s_bit;
    logic         carry_d;
    logic [W-1:0] acc_d;

    // One-bit full adder on the LSBs of the shifting operands.
    always_comb begin
        s_bit   = sa_q[0] ^ sb_q[0] ^ c_q;
        carry_d = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
        acc_d   = {s_bit, acc_q[W-1:1]};
    end

`ifdef SERIAL_SUB_EN
    // Subtract as a + ~b + ~cin; final carry inverted gives borrow.
    always_comb begin
        b_load = sub ? ~b : b;
        c_load = cin ^ sub;
        cout_d = carry_d ^ sub_q;
    end
`else
    // Add-only: operands and carry pass straight through.
    always_comb begin
        b_load = b;
        c_load = cin;
        cout_d = carry_d;
    end
`endif

    // Handshake FSM and serial datapath; all outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            acc_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b_load;
                        c_q     <= c_load;
                        cnt_q   <= '0;
`ifdef SERIAL_SUB_EN
                        sub_q   <= sub;
`endif
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    sa_q  <= {1'b0, sa_q[W-1:1]};
                    sb_q  <= {1'b0, sb_q[W-1:1]};
                    acc_q <= acc_d;
                    c_q   <= carry_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        // Last bit: publish result including the bit computed now.
                        sum_q   <= acc_d;
                        cout_q  <= cout_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed cases from the block's
// behaviour plus a long randomized run against an arithmetic reference model.
// Define SERIAL_SUB_EN to also exercise subtract mode.

module tb_serial_addsub;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_vec;
    int n_err;

    serial_addsub #(
        .W(W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
`ifdef SERIAL_SUB_EN
        .sub  (sub),
`endif
        .ready(ready),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic; returns {cout, sum}.
    function automatic logic [W:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                             input logic rcin, input logic rsub);
        longint unsigned x, y, total;
        x = longint'(ra);
        y = longint'(rb) + longint'(rcin);
        if (!rsub) begin
            total = x + y;
            return total[W:0];
        end else begin
            total = x - y;
            return {(x < y), total[W-1:0]};
        end
    endfunction

    function automatic logic pick_sub();
`ifdef SERIAL_SUB_EN
        return logic'($urandom_range(1, 0));
`else
        return 1'b0;
`endif
    endfunction

    task automatic wait_ready(input string tag);
        int guard;
        guard = 0;
        while (!ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq({tag, "_ready"}, ready, 1);
    endtask

    // One full operation with latency, busy-width and hold checks.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                          input logic tsub, input logic [W-1:0] exp_sum, input logic exp_cout,
                          input string tag);
        int            cycles;
        int            busy_cnt;
        logic          hold_ok;
        logic [W-1:0]  prev_sum;
        logic          prev_cout;
        wait_ready(tag);
        a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
        prev_sum = sum; prev_cout = cout;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = pick_sub();
        cycles = 1; busy_cnt = 0; hold_ok = 1'b1;
        while (!done && cycles < W + 6) begin
            if (busy) busy_cnt++;
            if (sum !== prev_sum || cout !== prev_cout) hold_ok = 1'b0;
            @(negedge clk);
            cycles++;
        end
        check_eq({tag, "_latency"}, cycles, W + 1);
        check_eq({tag, "_busy_cycles"}, busy_cnt, W);
        check_eq({tag, "_hold"}, hold_ok, 1);
        check_eq({tag, "_sum"}, sum, exp_sum);
        check_eq({tag, "_cout"}, cout, exp_cout);
        check_eq({tag, "_busy_at_done"}, busy, 0);
        @(negedge clk);
        check_eq({tag, "_done_width"}, done, 0);
        check_eq({tag, "_ready_after"}, ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [W:0] exp_q[$];
        logic [W:0] e;
        int         cyc;
        int         last_done;
        int         ops;
        int         dones;
        logic [W-1:0] seen_sum;

        n_vec = 0; n_err = 0;
        clk = 1'b0; rst = 1'b1; start = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        #1;
        check_eq("rst_ready", ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_sum", sum, 0);
        check_eq("rst_cout", cout, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, "add_5a_3c");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "add_ff_01");
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, "add_ff_ff_c");
`ifdef SERIAL_SUB_EN
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b1, "sub_05_07");
        run_op(8'h40, 8'h01, 1'b1, 1'b1, 8'h3E, 1'b0, "sub_40_01_b");
`endif

        // Start while busy must be ignored, not queued.
        wait_ready("ign");
        a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0; seen_sum = '0;
        for (int i = 0; i < 2 * W + 4; i++) begin
            if (done) begin
                dones++;
                seen_sum = sum;
            end
            @(negedge clk);
        end
        check_eq("ign_done_count", dones, 1);
        check_eq("ign_sum", seen_sum, 8'h30);
        check_eq("ign_cout", cout, 0);
        check_eq("ign_idle", ready, 1);

        // Abort mid-operation with reset after a known result of 0x96.
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, "pre_abort");
        wait_ready("abort");
        a = 8'h11; b = 8'h22; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_ready", ready, 1);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_sum", sum, 0);
        check_eq("abort_cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check_eq("abort_no_done", dones, 0);
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, "post_abort");

        // Randomized run with start held high: one op every W+2 cycles.
        wait_ready("rand");
        start = 1'b1;
        cyc = 0; last_done = -1; ops = 0;
        while (ops < 1000 && cyc < 20000) begin
            if (done) begin
                check_eq("rand_queue_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("rand_sum", sum, e[W-1:0]);
                    check_eq("rand_cout", cout, e[W]);
                end
                if (last_done >= 0) check_eq("rand_interval", cyc - last_done, W + 2);
                last_done = cyc;
                ops++;
            end
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = pick_sub();
            if (ready) exp_q.push_back(ref_model(a, b, cin, sub));
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_eq("rand_ops", ops, 1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
